// File: rtl/output_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : output_port_fifo
//  Description : First-word-fall-through output queue between the datapath
//                controller (writer) and a downstream consumer. Flags are
//                derived from registered state only; writes while full are
//                dropped and latched in a sticky overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_port_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       full,
    output logic                       stall,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int               C_AW         = $clog2(DEPTH);
    localparam logic [C_AW:0]    C_FULL_COUNT = (C_AW + 1)'(DEPTH);
    localparam logic [C_AW-1:0]  C_PTR_ONE    = C_AW'(1);
    localparam logic [C_AW:0]    C_CNT_ONE    = (C_AW + 1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [C_AW-1:0]  r_wr_ptr;
    logic [C_AW-1:0]  r_rd_ptr;
    logic [C_AW:0]    r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    // Status flags come purely from the registered occupancy count.
    always_comb begin
        w_full  = (r_count == C_FULL_COUNT);
        w_empty = (r_count == '0);
    end

    // A push is refused whenever the queue is full, even if a pop frees a
    // slot in the same cycle; the writer sees stall and retries next cycle.
    always_comb begin
        w_push = wr_en & ~w_full;
        w_pop  = ~w_empty & out_ready;
    end

    // Storage array: written on push only, never cleared by reset.
    always_ff @(posedge CLK) begin
        if (w_push && !reset) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and sticky overflow; reset discards queued data.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + C_CNT_ONE;
                2'b01:   r_count <= r_count - C_CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output mapping; out_data is the head entry straight from storage.
    always_comb begin
        full      = w_full;
        stall     = w_full;
        out_valid = ~w_empty;
        count     = r_count;
        overflow  = r_overflow;
        out_data  = r_mem[r_rd_ptr];
    end

endmodule
`default_nettype wire

// File: tb/tb_output_port_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_port_fifo
//  Description : Self-checking bench for output_port_fifo. A queue-based
//                reference model predicts every output after each edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_port_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             reset;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             full;
    logic             stall;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [CW-1:0]    count;
    logic             overflow;

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: plain queue of words plus sticky overflow bit.
    logic [WIDTH-1:0] m_q[$];
    bit               m_ovf;

    output_port_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .stall     (stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        chk("count",     32'(count),     32'(sz));
        chk("full",      32'(full),      32'(sz == DEPTH));
        chk("stall",     32'(stall),     32'(sz == DEPTH));
        chk("out_valid", 32'(out_valid), 32'(sz != 0));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        if (sz != 0) begin
            chk("out_data", 32'(out_data), 32'(m_q[0]));
        end
    endtask

    // One clock: apply inputs, advance the model, then check mid-cycle.
    task automatic step(input bit we, input logic [WIDTH-1:0] wd, input bit rdy, input bit rst);
        int  sz;
        bit  do_pop;
        bit  do_push;
        wr_en     = we;
        wr_data   = wd;
        out_ready = rdy;
        reset     = rst;
        sz        = m_q.size();
        if (rst) begin
            m_q.delete();
            m_ovf = 1'b0;
        end else begin
            do_pop  = (sz > 0) && rdy;
            do_push = we && (sz < DEPTH);
            if (we && sz == DEPTH) m_ovf = 1'b1;
            if (do_pop)  void'(m_q.pop_front());
            if (do_push) m_q.push_back(wd);
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        wr_en = 0; wr_data = '0; out_ready = 0; reset = 1;
        m_ovf = 0;
        @(negedge clk);
        step(0, '0, 0, 1);
        step(0, '0, 0, 1);

        // Single word through and out.
        step(1, 16'h1234, 0, 0);
        chk("single_data", 32'(out_data), 32'h1234);
        step(0, '0, 1, 0);
        chk("single_empty", 32'(out_valid), 32'h0);

        // Fill, overflow, drain.
        for (int i = 1; i <= 4; i++) step(1, WIDTH'(i), 0, 0);
        chk("fill_full", 32'(full), 32'h1);
        step(1, 16'h0005, 0, 0);
        chk("ovf_set", 32'(overflow), 32'h1);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

        // Full with simultaneous pop: write rejected, accepted next cycle.
        for (int i = 0; i < 4; i++) step(1, WIDTH'(16'h0010 + i), 0, 0);
        step(1, 16'h00AA, 1, 0);
        chk("fullpop_cnt", 32'(count), 32'd3);
        step(1, 16'h00AA, 0, 0);
        chk("retry_cnt", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) step(0, '0, 1, 0);

        // Clear overflow and stream across the wrap boundary.
        step(0, '0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            step(1, WIDTH'(16'h0100 + i), 1, 0);
            chk("stream_le1", 32'(count <= 1), 32'h1);
        end
        step(0, '0, 1, 0);

        // Reset mid-operation at count 3.
        for (int i = 0; i < 3; i++) step(1, WIDTH'(16'h0200 + i), 0, 0);
        step(1, 16'h0300, 0, 1);
        step(1, 16'hBEEF, 0, 0);
        chk("post_rst_head", 32'(out_data), 32'hBEEF);
        step(0, '0, 1, 0);

        // Backpressure hold at count 2.
        step(1, 16'h0401, 0, 0);
        step(1, 16'h0402, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, '0, 0, 0);
            chk("hold_data", 32'(out_data), 32'h0401);
        end
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            step(bit'($urandom_range(0, 1)), WIDTH'($urandom),
                 bit'($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
